// File: rtl/flappy_pkg.sv
// Shared encodings and screen geometry for the flappy datapath.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DEAD  = 2'b10
  } state_t;

  localparam int SCREEN_W  = 800;
  localparam int FLOOR_Y   = 490;
  localparam int CEIL_Y    = 10;
  localparam int BALL_SIZE = 10;

endpackage

// File: rtl/game_sequencer_btn_conditioner.sv
// Button synchronizer with frame-tick-gated rising-edge detect.
module btn_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  output logic press
);

  logic sync1, sync2, samp, armed;

  // The first tick after reset only loads the sample, so a held button is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      samp  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (tick) begin
        samp  <= sync2;
        armed <= 1'b1;
      end
    end
  end

  assign press = tick & armed & sync2 & ~samp;

endmodule

// File: rtl/game_sequencer.sv
// Frame-tick generation, READY/PLAY/DEAD sequencing, collision and pass scoring.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int BALL_SIZE = flappy_pkg::BALL_SIZE,
  parameter int FLOOR_Y   = flappy_pkg::FLOOR_Y,
  parameter int CEIL_Y    = flappy_pkg::CEIL_Y,
  parameter int DEAD_HOLD = 60,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         h_counter,
  input  logic [9:0]         v_counter,
  input  logic               btn_flap,
  input  logic               btn_reset,
  input  logic [9:0]         ballX,
  input  logic [9:0]         ballY,
  input  logic [9:0]         wallX,
  input  logic [9:0]         wallY,
  input  logic [9:0]         wallBaseX,
  input  logic [9:0]         wallBaseY,
  output logic               frame_tick,
  output logic               run_en,
  output logic               restart,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic               hit
);

  localparam logic [10:0] BALL_L  = 11'(BALL_SIZE);
  localparam logic [10:0] FLOOR_L = 11'(FLOOR_Y);
  localparam logic [10:0] CEIL_L  = 11'(CEIL_Y);
  localparam int          HOLD_W  = $clog2(DEAD_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(DEAD_HOLD);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t              state_r, state_nxt;
  logic [SCORE_W-1:0]  score_r, score_nxt;
  logic                hit_r, hit_nxt;
  logic [HOLD_W-1:0]   hold_r, hold_nxt;
  logic [10:0]         prev_wall_r;
  logic                flap_press, reset_press;

  btn_conditioner u_flap (
    .clk(clk), .rst(rst), .btn(btn_flap), .tick(frame_tick), .press(flap_press)
  );
  btn_conditioner u_reset (
    .clk(clk), .rst(rst), .btn(btn_reset), .tick(frame_tick), .press(reset_press)
  );

  logic [10:0] bx, by, wx, wy, wbx, wby, wall_r, wall_top;
  logic        overlap, collide, pass;

  assign bx  = {1'b0, ballX};
  assign by  = {1'b0, ballY};
  assign wx  = {1'b0, wallX};
  assign wy  = {1'b0, wallY};
  assign wbx = {1'b0, wallBaseX};
  assign wby = {1'b0, wallBaseY};

  assign wall_r   = wx + wbx;
  // A pipe taller than its base row is clamped to the top of the screen.
  assign wall_top = (wy > wby) ? 11'd0 : wby - wy;
  assign overlap  = (bx + BALL_L > wx) && (bx < wall_r) &&
                    (by + BALL_L > wall_top) && (by < wby);
  assign collide  = (by >= FLOOR_L) || (by < CEIL_L) || overlap;
  assign pass     = (prev_wall_r >= bx) && (wall_r < bx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick  <= 1'b0;
      state_r     <= ST_READY;
      score_r     <= '0;
      hit_r       <= 1'b0;
      hold_r      <= '0;
      prev_wall_r <= '0;
    end else begin
      frame_tick <= (h_counter == 10'd0) && (v_counter == 10'd0);
      if (frame_tick) begin
        state_r     <= state_nxt;
        score_r     <= score_nxt;
        hit_r       <= hit_nxt;
        hold_r      <= hold_nxt;
        prev_wall_r <= wall_r;
      end
    end
  end

  always_comb begin
    state_nxt = state_r;
    score_nxt = score_r;
    hit_nxt   = hit_r;
    hold_nxt  = hold_r;
    if (reset_press) begin
      state_nxt = ST_READY;
      score_nxt = '0;
      hit_nxt   = 1'b0;
      hold_nxt  = '0;
    end else begin
      unique case (state_r)
        ST_READY: begin
          score_nxt = '0;
          hit_nxt   = 1'b0;
          hold_nxt  = '0;
          if (flap_press) state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          if (collide) begin
            state_nxt = ST_DEAD;
            hit_nxt   = 1'b1;
            hold_nxt  = '0;
          end else if (pass && score_r != SCORE_MAX) begin
            score_nxt = score_r + SCORE_W'(1);
          end
        end
        ST_DEAD: begin
          if (hold_r != HOLD_MAX) hold_nxt = hold_r + HOLD_W'(1);
          if (flap_press && hold_r == HOLD_MAX) begin
            state_nxt = ST_READY;
            score_nxt = '0;
            hit_nxt   = 1'b0;
            hold_nxt  = '0;
          end
        end
        default: state_nxt = ST_READY;
      endcase
    end
  end

  assign state   = state_r;
  assign run_en  = (state_r == ST_PLAY);
  assign restart = (state_r == ST_READY);
  assign score   = score_r;
  assign hit     = hit_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Frame-level scoreboard bench for game_sequencer using a shortened 8x4 counter sweep.
module tb_game_sequencer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int FC = H * V;
  localparam logic [1:0] S_R = 2'b00;
  localparam logic [1:0] S_P = 2'b01;
  localparam logic [1:0] S_D = 2'b10;

  typedef struct {
    logic [1:0] st;
    logic [7:0] sc;
    logic       h;
  } exp_t;

  typedef struct {
    logic       flap;
    logic       rb;
    int         wx;
    int         wy;
    int         wby;
    int         by;
    logic [1:0] st;
    int         sc;
    logic       h;
  } row_t;

  logic       clk, rst;
  logic [9:0] h_counter, v_counter;
  logic       btn_flap, btn_reset;
  logic [9:0] ballX, ballY, wallX, wallY, wallBaseX, wallBaseY;
  logic       frame_tick, run_en, restart, hit;
  logic [1:0] state;
  logic [7:0] score;

  int   checks = 0;
  int   fails  = 0;
  int   ticks;
  exp_t sb[$];
  exp_t e;

  game_sequencer dut (
    .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
    .btn_flap(btn_flap), .btn_reset(btn_reset),
    .ballX(ballX), .ballY(ballY), .wallX(wallX), .wallY(wallY),
    .wallBaseX(wallBaseX), .wallBaseY(wallBaseY),
    .frame_tick(frame_tick), .run_en(run_en), .restart(restart),
    .state(state), .score(score), .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One counter sweep with (0,0) placed mid-frame so buttons settle before the tick.
  task automatic run_frame(input logic flap, input logic rb);
    int idx;
    ticks = 0;
    for (int c = 0; c < FC; c++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
      if (c == 0) begin
        btn_flap  = flap;
        btn_reset = rb;
      end
      idx = (c + FC / 2) % FC;
      h_counter = 10'(idx % H);
      v_counter = 10'(idx / H);
    end
    @(negedge clk);
    if (frame_tick === 1'b1) ticks++;
  endtask

  task automatic apply_row(input row_t r);
    wallX     = 10'(r.wx);
    wallY     = 10'(r.wy);
    wallBaseY = 10'(r.wby);
    ballY     = 10'(r.by);
    sb.push_back('{r.st, 8'(r.sc), r.h});
    run_frame(r.flap, r.rb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_flap = 1'b1;
    h_counter = 10'd0;
    v_counter = 10'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_tick, state, score, hit, run_en, restart} !== {1'b0, S_R, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_hold: tick=%0d st=%0d sc=%0d hit=%0d run=%0d restart=%0d, want 0 0 0 0 0 1",
               frame_tick, state, score, hit, run_en, restart);
    end
    h_counter = 10'd5;
    v_counter = 10'd3;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_row('{1, 0, 700, 100, 480, 300, S_R, 0, 0});
      e = sb.pop_front();
      checks++;
      if ({state, score, hit, run_en, restart} !== {e.st, e.sc, e.h, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL idle[%0d]: st=%0d sc=%0d run=%0d restart=%0d, want st=%0d sc=%0d",
                 i, state, score, run_en, restart, e.st, e.sc);
      end
      checks++;
      if (ticks !== 1) begin
        fails++;
        $display("FAIL tick_count[%0d]: got %0d ticks, want 1", i, ticks);
      end
    end
  endtask

  task automatic test_start();
    row_t t[4] = '{
      '{0, 0, 700, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 700, 100, 480, 300, S_P, 0, 0},
      '{1, 0, 700, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 700, 100, 480, 300, S_P, 0, 0}
    };
    for (int i = 0; i < 4; i++) begin
      apply_row(t[i]);
      e = sb.pop_front();
      checks++;
      if ({state, score, hit, run_en, restart} !== {e.st, e.sc, e.h, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL start[%0d]: st=%0d sc=%0d hit=%0d run=%0d restart=%0d, want st=%0d sc=%0d hit=%0d",
                 i, state, score, hit, run_en, restart, e.st, e.sc, e.h);
      end
    end
  endtask

  task automatic test_pass_scoring();
    row_t t[4] = '{
      '{0, 0, 561, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 560, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 559, 100, 480, 300, S_P, 1, 0},
      '{0, 0, 800, 100, 480, 300, S_P, 1, 0}
    };
    ballX = 10'd600;
    wallBaseX = 10'd40;
    for (int i = 0; i < 4; i++) begin
      apply_row(t[i]);
      e = sb.pop_front();
      checks++;
      if ({state, score, hit} !== {e.st, e.sc, e.h}) begin
        fails++;
        $display("FAIL pass[%0d]: st=%0d sc=%0d hit=%0d, want st=%0d sc=%0d hit=%0d",
                 i, state, score, hit, e.st, e.sc, e.h);
      end
    end
  endtask

  task automatic test_collisions();
    row_t t[19] = '{
      '{0, 0, 800, 100, 480, 495, S_D, 1, 1},
      '{0, 1, 800, 100, 480, 300, S_R, 0, 0},
      '{0, 0, 800, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 800, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 800, 100, 480, 489, S_P, 0, 0},
      '{0, 0, 800, 100, 480,  10, S_P, 0, 0},
      '{0, 0, 800, 100, 480,   9, S_D, 0, 1},
      '{0, 1, 800, 100, 480, 300, S_R, 0, 0},
      '{0, 0, 800, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 800, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 595, 370, 550, 300, S_D, 0, 1},
      '{0, 1, 800, 100, 480, 300, S_R, 0, 0},
      '{0, 0, 800, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 800, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 560, 100, 480, 300, S_P, 0, 0},
      '{0, 0, 559, 100, 480, 300, S_P, 1, 0},
      '{0, 0, 800, 100, 480, 300, S_P, 1, 0},
      '{0, 0, 560, 100, 480, 300, S_P, 1, 0},
      '{0, 0, 559, 100, 480, 495, S_D, 1, 1}
    };
    ballX = 10'd600;
    wallBaseX = 10'd40;
    for (int i = 0; i < 19; i++) begin
      apply_row(t[i]);
      e = sb.pop_front();
      checks++;
      if ({state, score, hit, run_en, restart} !== {e.st, e.sc, e.h, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL collide[%0d]: st=%0d sc=%0d hit=%0d run=%0d restart=%0d, want st=%0d sc=%0d hit=%0d",
                 i, state, score, hit, run_en, restart, e.st, e.sc, e.h);
      end
    end
  endtask

  // Flaps at DEAD ticks 10 and 60 arrive before the hold saturates; the one at 62 is accepted.
  task automatic test_dead_hold();
    row_t r;
    for (int k = 1; k <= 62; k++) begin
      r = '{(k == 10 || k == 60 || k == 62), 0, 559, 100, 480, 495,
            (k == 62) ? S_R : S_D, (k == 62) ? 0 : 1, (k != 62)};
      apply_row(r);
      e = sb.pop_front();
      checks++;
      if ({state, score, hit, run_en, restart} !== {e.st, e.sc, e.h, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL dead_hold[tick %0d]: st=%0d sc=%0d hit=%0d, want st=%0d sc=%0d hit=%0d",
                 k, state, score, hit, e.st, e.sc, e.h);
      end
    end
  endtask

  task automatic test_reset_button();
    row_t t[4] = '{
      '{0, 0, 800, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 800, 100, 480, 300, S_P, 0, 0},
      '{0, 1, 800, 100, 480, 300, S_R, 0, 0},
      '{0, 0, 800, 100, 480, 300, S_R, 0, 0}
    };
    for (int i = 0; i < 4; i++) begin
      apply_row(t[i]);
      e = sb.pop_front();
      checks++;
      if ({state, run_en, restart} !== {e.st, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL reset_btn[%0d]: st=%0d run=%0d restart=%0d, want st=%0d",
                 i, state, run_en, restart, e.st);
      end
    end
  endtask

  task automatic test_saturation();
    row_t r;
    int   n;
    ballX = 10'd600;
    wallBaseX = 10'd40;
    apply_row('{1, 0, 700, 100, 480, 300, S_P, 0, 0});
    e = sb.pop_front();
    checks++;
    if (state !== e.st) begin
      fails++;
      $display("FAIL sat_enter: st=%0d, want %0d", state, e.st);
    end
    for (int i = 0; i < 600; i++) begin
      n = (i + 1) / 2;
      r = '{0, 0, (i % 2 == 0) ? 700 : 559, 100, 480, 300, S_P, (n > 255) ? 255 : n, 0};
      apply_row(r);
      e = sb.pop_front();
      checks++;
      if ({state, score, hit} !== {e.st, e.sc, e.h}) begin
        fails++;
        $display("FAIL sat[%0d]: st=%0d sc=%0d hit=%0d, want st=%0d sc=%0d hit=%0d",
                 i, state, score, hit, e.st, e.sc, e.h);
      end
    end
    checks++;
    if (score !== 8'd255) begin
      fails++;
      $display("FAIL sat_final: score=%0d, want 255", score);
    end
  endtask

  task automatic test_mid_reset();
    row_t t[4] = '{
      '{1, 0, 700, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 700, 100, 480, 300, S_R, 0, 0},
      '{0, 0, 700, 100, 480, 300, S_R, 0, 0},
      '{1, 0, 700, 100, 480, 300, S_P, 0, 0}
    };
    btn_flap = 1'b1;
    h_counter = 10'd3;
    v_counter = 10'd1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    h_counter = 10'd0;
    v_counter = 10'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({frame_tick, state, score, hit, run_en, restart} !== {1'b0, S_R, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset: tick=%0d st=%0d sc=%0d hit=%0d run=%0d restart=%0d, want 0 0 0 0 0 1",
               frame_tick, state, score, hit, run_en, restart);
    end
    h_counter = 10'd4;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_row(t[i]);
      e = sb.pop_front();
      checks++;
      if ({state, score, run_en, restart} !== {e.st, e.sc, e.st == S_P, e.st == S_R}) begin
        fails++;
        $display("FAIL after_reset[%0d]: st=%0d sc=%0d run=%0d restart=%0d, want st=%0d sc=%0d",
                 i, state, score, run_en, restart, e.st, e.sc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_flap = 1'b0;
    btn_reset = 1'b0;
    h_counter = 10'd5;
    v_counter = 10'd3;
    ballX = 10'd100;
    ballY = 10'd300;
    wallX = 10'd700;
    wallY = 10'd100;
    wallBaseX = 10'd40;
    wallBaseY = 10'd480;
    test_reset();
    test_start();
    test_pass_scoring();
    test_collisions();
    test_dead_hold();
    test_reset_button();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
